// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D cache memory arbiter.
// State encoding, block geometry and memory latency live here.
package mem_arb_pkg;

   localparam int WORDS_PER_BLOCK = 8;
   localparam int MEM_LATENCY     = 4;
   localparam int OFFSET_W        = 4;
   localparam int CNT_W           = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      I_FILL  = 2'd1,
      D_FILL  = 2'd2,
      D_WRITE = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arb_counter.sv
// Small wrap-around counter with clear, increment and terminal count.
// Used for both the read-issue and the read-receive word index.
module mem_arb_counter #(
   parameter int           W    = 3,
   parameter logic [W-1:0] LAST = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         tc
);

   assign tc = (count == LAST);

   // clear wins over increment; the count wraps to zero after LAST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one 16-bit memory port between I-cache fills and
// D-cache fills/write-throughs; D wins unless I is owed a turn.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORDS_PER_BLOCK = mem_arb_pkg::WORDS_PER_BLOCK,
   parameter int MEM_LATENCY     = mem_arb_pkg::MEM_LATENCY
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        icache_req,
   input  logic [15:0] icache_addr,
   input  logic        dcache_req,
   input  logic        dcache_wr,
   input  logic [15:0] dcache_addr,
   input  logic [15:0] dcache_wdata,
   output logic [15:0] mem_addr,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_data_out,
   input  logic        mem_data_valid,
   output logic [15:0] fill_data,
   output logic [2:0]  fill_word,
   output logic        icache_fill_valid,
   output logic        dcache_fill_valid,
   output logic        icache_done,
   output logic        dcache_done,
   output logic        busy
);

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam int unused_latency = MEM_LATENCY;

   state_t                state_q, state_d;
   logic [15-OFFSET_W:0]  base_q;
   logic                  i_turn_q, iss_full_q, wr_sent_q;
   logic                  idone_q, ddone_q;
   logic                  gnt_i, gnt_d, issue, rx, last_rx, d_end;
   logic                  cnt_clr, iss_tc, rx_tc;
   logic [CNT_W-1:0]      iss_cnt, rx_cnt;
   logic [15:0]           fill_addr;
   logic                  unused;

   assign unused = ^{icache_addr[OFFSET_W-1:0], dcache_addr[0]};

   assign cnt_clr   = (state_q == IDLE);
   assign fill_addr = {base_q, {OFFSET_W{1'b0}}} + 16'({iss_cnt, 1'b0});
   assign d_end     = ((state_q == D_FILL) && last_rx) ||
                      ((state_q == D_WRITE) && !wr_sent_q);

   assign icache_done = idone_q;
   assign dcache_done = ddone_q;
   assign busy        = (state_q != IDLE);

   mem_arb_counter #(.W(CNT_W), .LAST(LAST_WORD)) u_iss (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (issue),
      .count (iss_cnt),
      .tc    (iss_tc)
   );

   mem_arb_counter #(.W(CNT_W), .LAST(LAST_WORD)) u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (rx),
      .count (rx_cnt),
      .tc    (rx_tc)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // grant decision, memory strobes, fill return and next state
   always_comb begin
      state_d           = state_q;
      gnt_i             = 1'b0;
      gnt_d             = 1'b0;
      issue             = 1'b0;
      rx                = 1'b0;
      last_rx           = 1'b0;
      mem_enable        = 1'b0;
      mem_wr            = 1'b0;
      mem_addr          = '0;
      mem_wdata         = '0;
      icache_fill_valid = 1'b0;
      dcache_fill_valid = 1'b0;
      fill_data         = '0;
      fill_word         = '0;
      unique case (state_q)
         IDLE: begin
            if (!idone_q && !ddone_q) begin
               if (icache_req && (i_turn_q || !dcache_req)) begin
                  gnt_i   = 1'b1;
                  state_d = I_FILL;
               end else if (dcache_req) begin
                  gnt_d   = 1'b1;
                  state_d = dcache_wr ? D_WRITE : D_FILL;
               end
            end
         end
         I_FILL, D_FILL: begin
            issue             = !iss_full_q;
            rx                = mem_data_valid;
            last_rx           = rx && rx_tc;
            mem_enable        = issue;
            mem_addr          = issue ? fill_addr : '0;
            icache_fill_valid = rx && (state_q == I_FILL);
            dcache_fill_valid = rx && (state_q == D_FILL);
            fill_data         = rx ? mem_data_out : '0;
            fill_word         = rx ? rx_cnt : '0;
            if (last_rx) begin
               state_d = IDLE;
            end
         end
         D_WRITE: begin
            if (!wr_sent_q) begin
               mem_enable = 1'b1;
               mem_wr     = 1'b1;
               mem_addr   = {dcache_addr[15:1], 1'b0};
               mem_wdata  = dcache_wdata;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // done pulses, block base, issue-complete flag and I fairness turn
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q     <= '0;
         i_turn_q   <= 1'b0;
         iss_full_q <= 1'b0;
         wr_sent_q  <= 1'b0;
         idone_q    <= 1'b0;
         ddone_q    <= 1'b0;
      end else begin
         idone_q   <= (state_q == I_FILL) && last_rx;
         ddone_q   <= d_end;
         wr_sent_q <= (state_q == D_WRITE) && !wr_sent_q;
         if (state_q == IDLE) begin
            iss_full_q <= 1'b0;
         end else if (issue && iss_tc) begin
            iss_full_q <= 1'b1;
         end
         if (gnt_i) begin
            base_q <= icache_addr[15:OFFSET_W];
         end else if (gnt_d) begin
            base_q <= dcache_addr[15:OFFSET_W];
         end
         if (gnt_i || gnt_d) begin
            i_turn_q <= 1'b0;
         end else if (d_end) begin
            i_turn_q <= icache_req;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency memory model.
// Requesters push expected words; a negedge monitor pops and compares.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int LAT = MEM_LATENCY;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        icache_req = 1'b0;
   logic [15:0] icache_addr = '0;
   logic        dcache_req = 1'b0;
   logic        dcache_wr = 1'b0;
   logic [15:0] dcache_addr = '0;
   logic [15:0] dcache_wdata = '0;
   logic [15:0] mem_addr, mem_wdata, mem_data_out, fill_data;
   logic        mem_enable, mem_wr, mem_data_valid;
   logic [2:0]  fill_word;
   logic        icache_fill_valid, dcache_fill_valid;
   logic        icache_done, dcache_done, busy;

   always #5 clk = ~clk;

   mem_arbiter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK), .MEM_LATENCY(LAT)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .icache_req        (icache_req),
      .icache_addr       (icache_addr),
      .dcache_req        (dcache_req),
      .dcache_wr         (dcache_wr),
      .dcache_addr       (dcache_addr),
      .dcache_wdata      (dcache_wdata),
      .mem_addr          (mem_addr),
      .mem_enable        (mem_enable),
      .mem_wr            (mem_wr),
      .mem_wdata         (mem_wdata),
      .mem_data_out      (mem_data_out),
      .mem_data_valid    (mem_data_valid),
      .fill_data         (fill_data),
      .fill_word         (fill_word),
      .icache_fill_valid (icache_fill_valid),
      .dcache_fill_valid (dcache_fill_valid),
      .icache_done       (icache_done),
      .dcache_done       (dcache_done),
      .busy              (busy)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return (a ^ 16'h3C5A) + {a[7:0], a[15:8]};
   endfunction

   // memory: each read returns mem_fn(addr) exactly LAT cycles later
   logic           stray = 1'b0;
   logic [LAT-1:0] lat_v = '0;
   logic [15:0]    lat_a [LAT] = '{default: 16'h0};

   always @(posedge clk) begin
      lat_v    <= {lat_v[LAT-2:0], mem_enable & ~mem_wr};
      lat_a[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) lat_a[i] <= lat_a[i-1];
   end

   assign mem_data_valid = lat_v[LAT-1] | stray;
   assign mem_data_out   = mem_fn(lat_a[LAT-1]);

   typedef struct packed {
      logic [2:0]  word;
      logic [15:0] data;
   } fill_t;

   fill_t       qi[$];
   fill_t       qd[$];
   logic [31:0] qw[$];
   logic [15:0] iss_log[$];
   string       order_log = "";

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_str(input string name, input string act,
                            input string exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, 64'({mem_addr, mem_enable, mem_wr, mem_wdata, fill_data,
                       fill_word, icache_fill_valid, dcache_fill_valid,
                       icache_done, dcache_done, busy}), 64'h0);
   endtask

   // monitor state
   logic  exp_id = 1'b0;
   logic  exp_dd = 1'b0;
   logic  busy_prev = 1'b0;
   int    n_ifill = 0;
   int    n_dfill = 0;
   int    busy_cnt = 0;
   int    id_cnt = 0;
   int    last_ddone_cyc = 0;
   int    last_rise_cyc = 0;
   fill_t ei, ed;
   logic [31:0] ew;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_id    = 1'b0;
         exp_dd    = 1'b0;
         busy_prev = 1'b0;
      end else begin
         if (icache_done || exp_id) check("icache_done", icache_done, exp_id);
         if (dcache_done || exp_dd) check("dcache_done", dcache_done, exp_dd);
         if (icache_done) id_cnt++;
         if (dcache_done) last_ddone_cyc = cyc;
         exp_id = 1'b0;
         exp_dd = 1'b0;
         if (busy && !busy_prev) last_rise_cyc = cyc;
         busy_prev = busy;
         if (busy) busy_cnt++;
         if (mem_enable && !mem_wr) iss_log.push_back(mem_addr);
         if (icache_fill_valid) begin
            n_ifill++;
            if (qi.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL i_fill_unexpected: got word %0d data %h expected none",
                        fill_word, fill_data);
            end else begin
               ei = qi.pop_front();
               check("i_fill", {fill_word, fill_data}, {ei.word, ei.data});
               if (ei.word == 3'd0) order_log = {order_log, "I"};
               if (ei.word == 3'(WORDS_PER_BLOCK - 1)) exp_id = 1'b1;
            end
         end
         if (dcache_fill_valid) begin
            n_dfill++;
            if (qd.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL d_fill_unexpected: got word %0d data %h expected none",
                        fill_word, fill_data);
            end else begin
               ed = qd.pop_front();
               check("d_fill", {fill_word, fill_data}, {ed.word, ed.data});
               if (ed.word == 3'd0) order_log = {order_log, "D"};
               if (ed.word == 3'(WORDS_PER_BLOCK - 1)) exp_dd = 1'b1;
            end
         end
         if (mem_wr) begin
            if (qw.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL d_write_unexpected: got addr %h data %h expected none",
                        mem_addr, mem_wdata);
            end else begin
               ew = qw.pop_front();
               check("d_write", {mem_enable, mem_addr, mem_wdata}, {1'b1, ew});
               order_log = {order_log, "W"};
               exp_dd = 1'b1;
            end
         end
      end
   end

   task automatic push_fill(input bit is_i, input logic [15:0] a);
      logic [15:0] base;
      fill_t f;
      base = {a[15:4], 4'h0};
      for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
         f.word = 3'(k);
         f.data = mem_fn(base + 16'(2 * k));
         if (is_i) qi.push_back(f);
         else qd.push_back(f);
      end
   endtask

   task automatic wait_done(input bit is_i);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk);
         ok = is_i ? icache_done : dcache_done;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL %s_done_timeout: got no done expected done within 400 cycles",
                  is_i ? "icache" : "dcache");
      end
   endtask

   task automatic req_i(input logic [15:0] a, input bit drop_early);
      push_fill(1'b1, a);
      icache_addr = a;
      icache_req  = 1'b1;
      if (drop_early) begin
         for (int n = 0; n < 50 && !busy; n++) @(negedge clk);
         icache_req  = 1'b0;
         icache_addr = 16'($urandom);
      end
      wait_done(1'b1);
      icache_req = 1'b0;
   endtask

   task automatic req_d(input logic [15:0] a, input bit wr,
                        input logic [15:0] wd, input bit hold);
      if (wr) qw.push_back({a[15:1], 1'b0, wd});
      else push_fill(1'b0, a);
      dcache_addr  = a;
      dcache_wr    = wr;
      dcache_wdata = wd;
      dcache_req   = 1'b1;
      wait_done(1'b0);
      if (!hold) dcache_req = 1'b0;
   endtask

   int b0, n0, n1, i0;

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset_outputs");
      rst_n = 1'b1;
      @(negedge clk);

      // single I fill, unaligned address
      iss_log.delete();
      req_i(16'h1236, 1'b0);
      repeat (2) @(negedge clk);
      check("s1_issue_count", iss_log.size(), 8);
      for (int k = 0; k < 8; k++) begin
         if (k < iss_log.size())
            check("s1_issue_addr", iss_log[k], 16'h1230 + 16'(2 * k));
      end
      check("s1_i_queue_drained", qi.size(), 0);

      // simultaneous I and D fill requests
      order_log = "";
      fork
         req_i(16'h2468, 1'b0);
         req_d(16'h4000, 1'b0, 16'h0, 1'b0);
      join
      repeat (2) @(negedge clk);
      check_str("s2_grant_order", order_log, "DI");
      check("s2_i_grant_gap", last_rise_cyc - last_ddone_cyc, 2);

      // write-through with stray valids around it
      stray = 1'b1;
      b0 = busy_cnt;
      req_d(16'h0010, 1'b1, 16'hBEEF, 1'b0);
      repeat (3) @(negedge clk);
      stray = 1'b0;
      check("s3_busy_cycles", busy_cnt - b0, 2);
      check("s3_write_drained", qw.size(), 0);

      // reset in the middle of an I fill
      n0 = n_ifill;
      push_fill(1'b1, 16'h5550);
      icache_addr = 16'h5550;
      icache_req  = 1'b1;
      for (int n = 0; n < 100 && (n_ifill - n0) < 3; n++) begin
         @(negedge clk);
         #2;
      end
      check("s4_words_before_reset", n_ifill - n0, 3);
      rst_n = 1'b0;
      #1;
      check_zero("s4_reset_outputs");
      icache_req = 1'b0;
      qi.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n1 = n_ifill + n_dfill;
      i0 = id_cnt;
      repeat (6) @(negedge clk);
      stray = 1'b1;
      repeat (2) @(negedge clk);
      stray = 1'b0;
      repeat (4) @(negedge clk);
      check("s4_no_fill_after_reset", (n_ifill + n_dfill) - n1, 0);
      check("s4_no_icache_done", id_cnt - i0, 0);

      // I request dropped right after grant
      i0 = id_cnt;
      req_i(16'h7A5C, 1'b1);
      repeat (2) @(negedge clk);
      check("s5_done_count", id_cnt - i0, 1);
      check("s5_i_queue_drained", qi.size(), 0);

      // continuous D with a pending I
      order_log = "";
      fork
         begin
            req_d(16'h8000, 1'b0, 16'h0, 1'b1);
            req_d(16'h9010, 1'b0, 16'h0, 1'b0);
         end
         begin
            @(negedge clk);
            req_i(16'hA0F0, 1'b0);
         end
      join
      repeat (2) @(negedge clk);
      check_str("s6_grant_order", order_log, "DID");

      // random mix of both requesters
      fork
         begin
            repeat (8) begin
               repeat ($urandom_range(0, 6)) @(negedge clk);
               req_i(16'($urandom), 1'b0);
            end
         end
         begin
            repeat (10) begin
               repeat ($urandom_range(0, 6)) @(negedge clk);
               req_d(16'($urandom), ($urandom_range(0, 2) == 0),
                     16'($urandom), 1'b0);
            end
         end
      join
      repeat (3) @(negedge clk);
      check("rand_i_drained", qi.size(), 0);
      check("rand_d_drained", qd.size(), 0);
      check("rand_w_drained", qw.size(), 0);
      check("rand_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
